bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/serializer_pkg.sv | 33 +++
 rtl/piso_shift_reg.sv | 38 +++
 rtl/bit_serializer.sv | 162 ++++++++++++++++
 tb/tb_bit_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// SERIALIZER_PARITY_EN adds the PARITY state and the even-parity helper.
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  // Width of bit_cnt; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: load has priority over shift,
// holds when neither is asserted; zeros are shifted in behind the data.
module piso_shift_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] sr_r;

  // Shift register storage with async clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sr_r <= data_in;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr_r <= {sr_r[WIDTH-2:0], 1'b0};
      end else begin
        sr_r <= {1'b0, sr_r[WIDTH-1:1]};
      end
    end else begin
      sr_r <= sr_r;
    end
  end

  assign serial_out = MSB_FIRST ? sr_r[WIDTH-1] : sr_r[0];

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bitstream serializer with valid/ready load handshake and stall.
// Define SERIALIZER_PARITY_EN to append an even-parity slot to every frame.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             bitstream,
  output logic             bit_valid,
  output logic             frame_done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          final_slot_s;
  logic          accept_s;
  logic          sr_shift_s;
  logic          sr_bit_s;
`ifdef SERIALIZER_PARITY_EN
  logic          parity_r;
`endif

  // Final-slot decode and handshake; ready is forced low while in reset.
  always_comb begin
    final_slot_s = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    final_slot_s = (state_r == PARITY);
`else
    final_slot_s = (state_r == SHIFT) && (cnt_r == LAST_CNT);
`endif
    load_ready = reset & ((state_r == IDLE) | (final_slot_s & shift_en));
    accept_s   = load_valid & load_ready;
    frame_done = final_slot_s & shift_en;
    bit_valid  = (state_r != IDLE);
  end

  // Next-state, counter and shift-enable decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sr_shift_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_r == LAST_CNT) begin
`ifdef SERIALIZER_PARITY_EN
            state_nxt_s = PARITY;
            cnt_nxt_s   = {CW{1'b0}};
            sr_shift_s  = 1'b1;
`else
            cnt_nxt_s = {CW{1'b0}};
            if (accept_s) begin
              state_nxt_s = SHIFT;
            end else begin
              state_nxt_s = IDLE;
              sr_shift_s  = 1'b1;
            end
`endif
          end else begin
            cnt_nxt_s  = cnt_r + CW'(1'b1);
            sr_shift_s = 1'b1;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          cnt_nxt_s = {CW{1'b0}};
          if (accept_s) begin
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state and bit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  // Parity of the accepted word, captured alongside the data load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_r <= 1'b0;
    end else if (accept_s) begin
      parity_r <= even_parity(32'(data_in));
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .shift     (sr_shift_s),
    .data_in   (data_in),
    .serial_out(sr_bit_s)
  );

  // Serial output mux; quiet whenever no real bit is being presented.
  always_comb begin
    bitstream = 1'b0;
    if (bit_valid) begin
`ifdef SERIALIZER_PARITY_EN
      if (state_r == PARITY) begin
        bitstream = parity_r;
      end else begin
        bitstream = sr_bit_s;
      end
`else
      bitstream = sr_bit_s;
`endif
    end else begin
      bitstream = 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8, MSB first).
// Honours SERIALIZER_PARITY_EN by expecting a trailing parity slot per frame.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       load_valid = 1'b0;
  logic       shift_en   = 1'b0;
  logic [7:0] data_in    = 8'h00;
  logic       load_ready;
  logic       bitstream;
  logic       bit_valid;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;

  bit_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .shift_en  (shift_en),
    .bitstream (bitstream),
    .bit_valid (bit_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Slot k (0-based) of a frame: data bits MSB first, then even parity.
  function automatic logic exp_bit(input logic [7:0] w, input int k);
    if (k < 8) return w[7-k];
    else return ^w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; data_in = 8'hB6; shift_en = 1'b1;
    repeat (3) step();
    #1;
    vectors++;
    if ({bitstream, bit_valid, frame_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, want 000", {bitstream, bit_valid, frame_done});
    end
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_load_ready: got %b, want 0", load_ready);
    end
  endtask

  task automatic test_single();
    logic eb;
    step();
    reset = 1'b1; load_valid = 1'b1; data_in = 8'hB6; shift_en = 1'b0;
    #1;
    vectors++;
    if (load_ready !== 1'b1 || bit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready: ready=%b valid=%b, want 1 0", load_ready, bit_valid);
    end
    shift_en = 1'b1;
    for (int k = 1; k <= FL; k++) begin
      step();
      load_valid = 1'b0; data_in = 8'h00;
      #1;
      eb = exp_bit(8'hB6, k - 1);
      vectors++;
      if (bitstream !== eb || bit_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL single_bit c%0d: got %b/%b, want %b/1", k, bitstream, bit_valid, eb);
      end
      vectors++;
      if (frame_done !== (k == FL) || load_ready !== (k == FL)) begin
        miscompares++;
        $display("FAIL single_done c%0d: done=%b ready=%b, want %b", k, frame_done, load_ready, (k == FL));
      end
    end
    step();
    #1;
    vectors++;
    if (bit_valid !== 1'b0 || bitstream !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: valid=%b bit=%b, want 0 0", bit_valid, bitstream);
    end
  endtask

  task automatic test_back_to_back();
    logic       eb;
    logic [7:0] w;
    load_valid = 1'b1; data_in = 8'hB6;
    for (int k = 1; k <= 2 * FL; k++) begin
      step();
      if (k >= 2 && k < FL) begin
        load_valid = 1'b1; data_in = 8'hFF;
      end else if (k == FL) begin
        load_valid = 1'b1; data_in = 8'h0B;
      end else begin
        load_valid = 1'b0; data_in = 8'h00;
      end
      #1;
      w  = (k <= FL) ? 8'hB6 : 8'h0B;
      eb = exp_bit(w, (k - 1) % FL);
      vectors++;
      if (bitstream !== eb || bit_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_bit c%0d: got %b/%b, want %b/1", k, bitstream, bit_valid, eb);
      end
      vectors++;
      if (frame_done !== (k == FL || k == 2 * FL) || load_ready !== (k == FL || k == 2 * FL)) begin
        miscompares++;
        $display("FAIL b2b_done c%0d: done=%b ready=%b", k, frame_done, load_ready);
      end
    end
    step();
    #1;
    vectors++;
    if (bit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: valid=%b, want 0", bit_valid);
    end
  endtask

  task automatic test_stall();
    int   idx;
    logic eb;
    logic last;
    idx = 0;
    load_valid = 1'b1; data_in = 8'hB6; shift_en = 1'b1;
    for (int k = 1; k <= FL + 3; k++) begin
      step();
      load_valid = 1'b0;
      shift_en = !(k >= 3 && k <= 5);
      #1;
      eb   = exp_bit(8'hB6, idx);
      last = (idx == FL - 1) && shift_en;
      vectors++;
      if (bitstream !== eb || bit_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_bit c%0d: got %b/%b, want %b/1", k, bitstream, bit_valid, eb);
      end
      vectors++;
      if (load_ready !== last || frame_done !== last) begin
        miscompares++;
        $display("FAIL stall_ready c%0d: ready=%b done=%b, want %b", k, load_ready, frame_done, last);
      end
      if (shift_en) idx++;
    end
    step();
    shift_en = 1'b1;
    #1;
    vectors++;
    if (bit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: valid=%b, want 0", bit_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic eb;
    load_valid = 1'b1; data_in = 8'hB6; shift_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      load_valid = 1'b0;
      #1;
      eb = exp_bit(8'hB6, k - 1);
      vectors++;
      if (bitstream !== eb) begin
        miscompares++;
        $display("FAIL mid_pre c%0d: got %b, want %b", k, bitstream, eb);
      end
    end
    step();
    reset = 1'b0; load_valid = 1'b1; data_in = 8'hFF;
    #1;
    vectors++;
    if ({bitstream, bit_valid, frame_done, load_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: got %b, want 0000", {bitstream, bit_valid, frame_done, load_ready});
    end
    step();
    step();
    reset = 1'b1; load_valid = 1'b1; data_in = 8'h0B;
    for (int k = 1; k <= FL; k++) begin
      step();
      load_valid = 1'b0;
      #1;
      eb = exp_bit(8'h0B, k - 1);
      vectors++;
      if (bitstream !== eb || bit_valid !== 1'b1 || frame_done !== (k == FL)) begin
        miscompares++;
        $display("FAIL mid_post c%0d: bit=%b valid=%b done=%b, want %b 1 %b", k, bitstream, bit_valid, frame_done, eb, (k == FL));
      end
    end
    step();
    #1;
    vectors++;
    if (bit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_end: valid=%b, want 0", bit_valid);
    end
  endtask

`ifndef SERIALIZER_PARITY_EN
  // Overlapping "1101" detector fed from the stream; frames B6,B6 give
  // hits on stream bits 6, 9 (spanning the frame boundary) and 14.
  task automatic test_detector();
    logic [3:0] window;
    logic       pulse;
    logic       exp_pulse;
    int         hits;
    window = 4'b0000; hits = 0;
    load_valid = 1'b1; data_in = 8'hB6; shift_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      load_valid = (k == 8);
      #1;
      if (bit_valid) window = {window[2:0], bitstream};
      pulse     = bit_valid && (window == 4'b1101);
      exp_pulse = (k == 6 || k == 9 || k == 14);
      if (pulse) hits++;
      vectors++;
      if (pulse !== exp_pulse) begin
        miscompares++;
        $display("FAIL detect c%0d: pulse=%b, want %b", k, pulse, exp_pulse);
      end
    end
    vectors++;
    if (hits !== 3) begin
      miscompares++;
      $display("FAIL detect_count: got %0d, want 3", hits);
    end
    load_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
`ifndef SERIALIZER_PARITY_EN
    test_detector();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
